cpu6502_int_ctrl: RTL and testbench

Parametrised interrupt controller for the 6502 core. It collects up to 8 external interrupt sources and routes each to the core's `irq` or `nmi` input. It snoops the core's vector fetches to acknowledge the serviced channel, and remaps the FFFE/FFFF (IRQ) and FFFA/FFFB (NMI) vector reads to a per-channel vector table. It sits between the core's `aout`/`mr` outputs and the memory address decoder.

---
 rtl/cpu6502_int_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cpu6502_int_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6502_int_ctrl.sv
// cpu6502_int_ctrl -- interrupt controller for the 6502 core.
//
// Collects up to NCH external interrupt sources and routes each one to the
// core's level IRQ or its NMI request. The controller snoops the core's
// vector fetches to acknowledge the channel being serviced. It can also
// remap the IRQ (FFFE/FFFF) and NMI (FFFA/FFFB) vector reads into a
// per-channel vector table.
//
// Build option:
//   INTC_REMAP_EN  defined   : vector reads are redirected to the table.
//                  undefined : aout_remap == cpu_aout; software reads STATUS.
//
// Parameters:
//   NCH       number of source channels (1..8)
//   VEC_BASE  base address of the vector table
//             IRQ vector of channel i : VEC_BASE + 2*i
//             NMI vector of channel i : VEC_BASE + 2*NCH + 2*i
//
// Ports:
//   clk, reset  system clock; asynchronous active-high reset
//   ce          clock enable shared with the core
//   src         raw interrupt sources (asynchronous to clk)
//   reg_sel     register select: 0 MASK, 1 MODE, 2 PEND, 3 NMISEL, 4 STATUS
//   reg_wr      register write strobe (qualified by ce)
//   reg_din     register write data
//   reg_dout    register read data (combinational)
//   cpu_aout    core address bus
//   cpu_mr      core read strobe
//   irq, nmi    registered requests to the core
//   aout_remap  address presented to the memory decoder
module cpu6502_int_ctrl #(
  parameter int unsigned NCH      = 8,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic [NCH-1:0] src,
  input  logic [2:0]     reg_sel,
  input  logic           reg_wr,
  input  logic [7:0]     reg_din,
  output logic [7:0]     reg_dout,
  input  logic [15:0]    cpu_aout,
  input  logic           cpu_mr,
  output logic           irq,
  output logic           nmi,
  output logic [15:0]    aout_remap
);

  // Channels at index NCH and above are hard-wired to zero.
  localparam logic [7:0] CH_MASK = 8'((16'd1 << NCH) - 16'd1);

  typedef enum logic {
    ST_IDLE,
    ST_LOW_SEEN
  } state_t;

  logic [7:0] src_ext;
  logic [7:0] sync1_q, sync_q, sync_d_q;
  logic [7:0] mask_q, mode_q, pend_q, nmisel_q;
  logic [7:0] pend_d;
  logic [7:0] edge_set, wr_clr, ack_vec;
  logic [7:0] irq_set, nmi_set;
  logic [2:0] irq_id, nmi_id;
  logic       wr_en;

  state_t     state_q, state_d;
  logic [2:0] id_q, id_d;
  logic       valid_q, valid_d;
  logic       nmi_flag_q, nmi_flag_d;
  logic       ack;

  logic       lo_irq, lo_nmi, low_hit, high_hit;
  logic       lo_valid;
  logic [2:0] lo_id;
  logic [15:0] hi_addr;

  // Lowest set index wins.
  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign src_ext = 8'(src) & CH_MASK;
  assign wr_en   = ce & reg_wr;

  // ---------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      sync_d_q <= '0;
    end else if (ce) begin
      sync1_q  <= src_ext;
      sync_q   <= sync1_q;
      sync_d_q <= sync_q;
    end
  end

  assign edge_set = sync_q & ~sync_d_q;

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      mode_q   <= '0;
      nmisel_q <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        3'd0:    mask_q   <= reg_din & CH_MASK;
        3'd1:    mode_q   <= reg_din & CH_MASK;
        3'd3:    nmisel_q <= reg_din & CH_MASK;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pending register
  // Edge bits: a new edge beats a write-1-clear or acknowledge in the same
  // cycle. Level bits simply follow the synchronized source.
  // ---------------------------------------------------------------------
  assign wr_clr  = (wr_en && reg_sel == 3'd2) ? reg_din : '0;
  assign ack_vec = ack ? (8'd1 << id_q) : '0;

  always_comb begin
    pend_d = ((mode_q & (edge_set | (pend_q & ~wr_clr & ~ack_vec)))
            | (~mode_q & sync_q)) & CH_MASK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else if (ce) begin
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------
  // Request outputs
  // ---------------------------------------------------------------------
  assign irq_set = pend_q & mask_q & ~nmisel_q;
  assign nmi_set = pend_q & mask_q & nmisel_q;
  assign irq_id  = prio(irq_set);
  assign nmi_id  = prio(nmi_set);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
      nmi <= 1'b0;
    end else if (ce) begin
      irq <= |irq_set;
      nmi <= |nmi_set;
    end
  end

  // ---------------------------------------------------------------------
  // Vector fetch snoop
  // ---------------------------------------------------------------------
  assign lo_irq   = cpu_mr && (cpu_aout == 16'hFFFE);
  assign lo_nmi   = cpu_mr && (cpu_aout == 16'hFFFA);
  assign low_hit  = (state_q == ST_IDLE) && (lo_irq || lo_nmi);
  assign lo_valid = lo_nmi ? |nmi_set : |irq_set;
  assign lo_id    = lo_nmi ? nmi_id : irq_id;

  // The high-byte fetch must match the kind of vector whose low byte was seen.
  assign hi_addr  = nmi_flag_q ? 16'hFFFB : 16'hFFFF;
  assign high_hit = (state_q == ST_LOW_SEEN) && cpu_mr && valid_q &&
                    (cpu_aout == hi_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      valid_q    <= 1'b0;
      nmi_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      nmi_flag_q <= nmi_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    valid_d    = valid_q;
    nmi_flag_d = nmi_flag_q;
    ack        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ce && low_hit) begin
          state_d    = ST_LOW_SEEN;
          id_d       = lo_id;
          valid_d    = lo_valid;
          nmi_flag_d = lo_nmi;
        end
      end
      ST_LOW_SEEN: begin
        // Any read completes the sequence; only the matching high byte acks.
        if (ce && cpu_mr) begin
          state_d = ST_IDLE;
          ack     = high_hit;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Address remap
  // ---------------------------------------------------------------------
`ifdef INTC_REMAP_EN
  localparam logic [15:0] NMI_OFS = 16'(2 * NCH);

  logic [2:0]  vec_id;
  logic        vec_nmi;
  logic [15:0] vec_addr;

  always_comb begin
    vec_id   = high_hit ? id_q : lo_id;
    vec_nmi  = high_hit ? nmi_flag_q : lo_nmi;
    vec_addr = VEC_BASE + (vec_nmi ? NMI_OFS : 16'd0) + {12'd0, vec_id, 1'b0};
    if (low_hit && lo_valid) begin
      aout_remap = vec_addr;
    end else if (high_hit) begin
      aout_remap = vec_addr + 16'd1;
    end else begin
      aout_remap = cpu_aout;
    end
  end
`else
  assign aout_remap = cpu_aout;
`endif

  // ---------------------------------------------------------------------
  // Register read
  // ---------------------------------------------------------------------
  always_comb begin
    case (reg_sel)
      3'd0:    reg_dout = mask_q;
      3'd1:    reg_dout = mode_q;
      3'd2:    reg_dout = pend_q;
      3'd3:    reg_dout = nmisel_q;
      3'd4:    reg_dout = {valid_q, 3'b000, nmi_flag_q, id_q};
      default: reg_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu6502_int_ctrl.sv
module tb_cpu6502_int_ctrl;

  localparam int unsigned NCH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           ce;
  logic [NCH-1:0] src;
  logic [2:0]     reg_sel;
  logic           reg_wr;
  logic [7:0]     reg_din;
  logic [7:0]     reg_dout;
  logic [15:0]    cpu_aout;
  logic           cpu_mr;
  logic           irq;
  logic           nmi;
  logic [15:0]    aout_remap;

  int n_checks = 0;
  int n_fail   = 0;

  cpu6502_int_ctrl #(
    .NCH      (NCH),
    .VEC_BASE (16'hFFE0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .src        (src),
    .reg_sel    (reg_sel),
    .reg_wr     (reg_wr),
    .reg_din    (reg_din),
    .reg_dout   (reg_dout),
    .cpu_aout   (cpu_aout),
    .cpu_mr     (cpu_mr),
    .irq        (irq),
    .nmi        (nmi),
    .aout_remap (aout_remap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ce;
    logic [2:0] sel;
    logic       wr;
    logic [7:0] din;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[11];

  // Expected address when remap is built in, raw address otherwise.
  function automatic logic [15:0] rm(input logic [15:0] remapped, input logic [15:0] raw);
`ifdef INTC_REMAP_EN
    return remapped;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] val);
    reg_sel = sel;
    reg_din = val;
    reg_wr  = 1'b1;
    tick();
    reg_wr  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, output logic [7:0] val);
    reg_sel = sel;
    #1;
    val = reg_dout;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] sel, input logic [7:0] exp);
    logic [7:0] v;
    rd(sel, v);
    check(name, {8'h00, v}, {8'h00, exp});
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    src = m;
    tick();
    src = '0;
  endtask

  task automatic fetch(input string name, input logic [15:0] addr, input logic [15:0] exp);
    cpu_aout = addr;
    cpu_mr   = 1'b1;
    #1;
    check(name, aout_remap, exp);
    @(posedge clk);
    #1;
    cpu_mr   = 1'b0;
    cpu_aout = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    ce       = 1'b1;
    src      = '0;
    reg_sel  = '0;
    reg_wr   = 1'b0;
    reg_din  = '0;
    cpu_aout = 16'hFFFE;
    cpu_mr   = 1'b1;

    //            ce   sel   wr   din    exp
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 8'hFF, 8'h0F};
    vecs[1]  = '{1'b1, 3'd1, 1'b1, 8'h5A, 8'h0A};
    vecs[2]  = '{1'b1, 3'd3, 1'b1, 8'h33, 8'h03};
    vecs[3]  = '{1'b0, 3'd0, 1'b1, 8'h00, 8'h0F};
    vecs[4]  = '{1'b1, 3'd5, 1'b1, 8'hFF, 8'h00};
    vecs[5]  = '{1'b1, 3'd4, 1'b1, 8'hFF, 8'h00};
    vecs[6]  = '{1'b1, 3'd2, 1'b1, 8'hFF, 8'h00};
    vecs[7]  = '{1'b1, 3'd3, 1'b1, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 3'd1, 1'b1, 8'h0F, 8'h0F};
    vecs[9]  = '{1'b1, 3'd7, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 3'd0, 1'b0, 8'h00, 8'h0F};

    // Reset state
    ticks(3);
    check("reset_irq", {15'd0, irq}, 16'd0);
    check("reset_nmi", {15'd0, nmi}, 16'd0);
    check("reset_remap", aout_remap, 16'hFFFE);
    chk_reg("reset_mask", 3'd0, 8'h00);
    chk_reg("reset_pend", 3'd2, 8'h00);
    chk_reg("reset_status", 3'd4, 8'h00);
    cpu_mr   = 1'b0;
    cpu_aout = 16'h0000;
    reset    = 1'b0;
    tick();

    // Register access table
    for (int i = 0; i < 11; i++) begin
      ce      = vecs[i].ce;
      reg_sel = vecs[i].sel;
      reg_din = vecs[i].din;
      reg_wr  = vecs[i].wr;
      tick();
      reg_wr  = 1'b0;
      ce      = 1'b1;
      chk_reg($sformatf("regvec%0d", i), vecs[i].sel, vecs[i].exp);
    end

    // Single edge channel: MASK=0F MODE=0F NMISEL=00
    pulse(4'b0100);
    ticks(2);
    chk_reg("ch2_pend_lat3", 3'd2, 8'h04);
    check("ch2_irq_lat3", {15'd0, irq}, 16'd0);
    tick();
    check("ch2_irq_lat4", {15'd0, irq}, 16'd1);
    fetch("ch2_lo", 16'hFFFE, rm(16'hFFE4, 16'hFFFE));
    fetch("ch2_hi", 16'hFFFF, rm(16'hFFE5, 16'hFFFF));
    chk_reg("ch2_pend_ack", 3'd2, 8'h00);
    chk_reg("ch2_status", 3'd4, 8'h82);
    tick();
    check("ch2_irq_clr", {15'd0, irq}, 16'd0);

    // Two channels: lowest index wins
    pulse(4'b1010);
    ticks(3);
    check("ch13_irq", {15'd0, irq}, 16'd1);
    fetch("ch1_lo", 16'hFFFE, rm(16'hFFE2, 16'hFFFE));
    fetch("ch1_hi", 16'hFFFF, rm(16'hFFE3, 16'hFFFF));
    chk_reg("ch1_status", 3'd4, 8'h81);
    chk_reg("ch1_pend", 3'd2, 8'h08);
    tick();
    check("ch3_irq_held", {15'd0, irq}, 16'd1);
    fetch("ch3_lo", 16'hFFFE, rm(16'hFFE6, 16'hFFFE));
    fetch("ch3_hi", 16'hFFFF, rm(16'hFFE7, 16'hFFFF));
    chk_reg("ch3_status", 3'd4, 8'h83);
    ticks(2);
    check("ch3_irq_clr", {15'd0, irq}, 16'd0);

    // NMI routing
    wr(3'd3, 8'h01);
    pulse(4'b0001);
    ticks(3);
    check("nmi_set", {15'd0, nmi}, 16'd1);
    check("nmi_noirq", {15'd0, irq}, 16'd0);
    fetch("nmi_lo", 16'hFFFA, rm(16'hFFE8, 16'hFFFA));
    chk_reg("nmi_status", 3'd4, 8'h88);
    fetch("nmi_hi", 16'hFFFB, rm(16'hFFE9, 16'hFFFB));
    ticks(2);
    check("nmi_clr", {15'd0, nmi}, 16'd0);
    wr(3'd3, 8'h00);

    // Level channel ignores write-1-clear and follows the source
    wr(3'd1, 8'h00);
    src = 4'b0001;
    ticks(3);
    chk_reg("lvl_pend", 3'd2, 8'h01);
    wr(3'd2, 8'h01);
    chk_reg("lvl_w1c_ignored", 3'd2, 8'h01);
    src = '0;
    ticks(2);
    chk_reg("lvl_rel_2", 3'd2, 8'h01);
    tick();
    chk_reg("lvl_rel_3", 3'd2, 8'h00);

    // Edge set coinciding with write-1-clear: set wins, then clears
    wr(3'd1, 8'h0F);
    pulse(4'b0010);
    tick();
    wr(3'd2, 8'h02);
    chk_reg("set_wins_w1c", 3'd2, 8'h02);
    wr(3'd2, 8'h02);
    chk_reg("w1c_edge", 3'd2, 8'h00);
    ticks(2);

    // Empty IRQ set (BRK): no remap, valid=0
    fetch("brk_lo", 16'hFFFE, 16'hFFFE);
    chk_reg("brk_status", 3'd4, 8'h00);
    fetch("brk_hi", 16'hFFFF, 16'hFFFF);

    // Reset vector never matches
    pulse(4'b0100);
    ticks(3);
    fetch("rst_vec", 16'hFFFC, 16'hFFFC);
    chk_reg("rst_vec_status", 3'd4, 8'h00);
    fetch("rst_vec_hi", 16'hFFFF, 16'hFFFF);
    chk_reg("rst_vec_pend", 3'd2, 8'h04);

    // Reset between low and high byte fetches
    fetch("mid_lo", 16'hFFFE, rm(16'hFFE4, 16'hFFFE));
    chk_reg("mid_status", 3'd4, 8'h82);
    reset = 1'b1;
    #2;
    check("mid_irq", {15'd0, irq}, 16'd0);
    chk_reg("mid_pend", 3'd2, 8'h00);
    chk_reg("mid_status_rst", 3'd4, 8'h00);
    reset = 1'b0;
    fetch("mid_hi", 16'hFFFF, 16'hFFFF);
    chk_reg("mid_status_after", 3'd4, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
